kia_queue: RTL and testbench
============================

KIA_QUEUE -- requirements
Module: kia_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4: queue depth is 2**DEPTH_LOG2 bytes; legal range 1..6.
REQ-002 SHALL have port CLK_I, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RES_I, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port ADR_I, input, 1, register select: 0 = status, 1 = queue head.
REQ-005 SHALL have port WE_I, input, 1, bus write enable.
REQ-006 SHALL have port CYC_I, input, 1, bus cycle valid.
REQ-007 SHALL have port STB_I, input, 1, bus strobe.
REQ-008 SHALL have port DAT_I, input, 8, bus write data.
REQ-009 SHALL have port ACK_O, output, 1, bus acknowledge.
REQ-010 SHALL have port DAT_O, output, 8, bus read data.
REQ-011 SHALL have port BYTE_I, input, 8, scan-code byte from the PS/2 deserializer.
REQ-012 SHALL have port BYTE_STB_I, input, 1, single-cycle pulse: BYTE_I is valid.

Function
REQ-013 SHALL define accept = CYC_I & STB_I & ~ACK_O.
REQ-014 SHALL register ACK_O <= accept, giving exactly one ACK_O pulse per transaction, one cycle after setup.
REQ-015 SHALL load DAT_O on accept of a read (WE_I=0), and SHALL hold DAT_O otherwise.
REQ-016 SHALL load, on a status read (ADR_I=0): bit0 = 1 if empty; bit1 = 1 if full; bit2 = overrun (see REQ-029); bits7:3 = 0.
REQ-017 SHALL, on a head read (ADR_I=1) with queue non-empty: load the head byte into DAT_O and pop exactly one entry.
REQ-018 SHALL, on a head read (ADR_I=1) with queue empty: load 0x00 into DAT_O and leave the queue unchanged.
REQ-019 SHALL push BYTE_I on a cycle where BYTE_STB_I=1 and the queue is not full.
REQ-020 SHALL drop the byte when BYTE_STB_I=1, the queue is full, and no pop occurs in that cycle.
REQ-021 SHALL keep read/write pointers DEPTH_LOG2 bits wide, wrapping modulo depth.
REQ-022 SHALL keep an occupancy count DEPTH_LOG2+1 bits wide, range 0..depth.
REQ-023 SHALL, on a simultaneous push and pop: perform both, leave count unchanged, and accept the push even when full.
REQ-024 SHALL, on a push coinciding with a head read of an empty queue: return 0x00 and end with count 1.
REQ-025 SHALL compute status bits from state before the clock edge on which they are loaded.
REQ-026 SHALL acknowledge writes normally; writes SHALL have no effect except REQ-030.

Reset
REQ-027 SHALL, while RES_I=1, asynchronously force: ACK_O=0; DAT_O=0x00; pointers = 0; count = 0; overrun = 0.
REQ-028 SHALL, on RES_I asserted mid-transaction or mid-push, discard that transaction or push with no pop, push or ACK_O.

Configuration
REQ-029 SHALL, with KIA_OVERRUN_FLAG_EN defined, implement a sticky overrun flag set by any dropped byte (REQ-020) and reported in status bit2.
REQ-030 SHALL, with KIA_OVERRUN_FLAG_EN defined, clear overrun on an accepted write to ADR_I=0 with DAT_I bit2=1; a set-event in the same cycle takes priority.
REQ-031 SHALL, without KIA_OVERRUN_FLAG_EN: drop bytes silently, read status bit2 as 0, and contain no overrun register.

Verification
REQ-032 SHALL cover: reset, then read ADR 0 -> ACK_O exactly one cycle later, DAT_O=0x01.
REQ-033 SHALL cover: push 0x1C, 0x32 -> status 0x00; head reads return 0x1C then 0x32; status then 0x01; a further head read returns 0x00.
REQ-034 SHALL cover: with DEPTH_LOG2=4, push 0x00..0x10 (17 bytes) -> status 0x06 (0x02 without the macro); 16 head reads return 0x00..0x0F; 0x10 is lost.
REQ-035 SHALL cover: with the queue full, BYTE_STB_I coincides with the head-read accept -> count stays 16, overrun stays 0, last byte read is the coinciding byte.
REQ-036 SHALL cover: with overrun set, write 0x04 to ADR 0 -> subsequent status bit2=0; write 0x00 -> bit2 remains set.
REQ-037 SHALL cover: CYC_I/STB_I held high for 4 cycles on ADR 1 -> ACK_O pulses on alternate cycles, exactly one pop per ACK_O.

Source files
------------

// File: rtl/kia_queue.sv
// rtl/kia_queue.sv - PS/2 scan-code byte queue behind a two-register bus slave.
// Optional sticky overrun flag: define KIA_OVERRUN_FLAG_EN.
module kia_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       CLK_I,
    input  logic       RES_I,
    input  logic       ADR_I,
    input  logic       WE_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] BYTE_I,
    input  logic       BYTE_STB_I
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;

    logic accept;
    logic rd_acc;
    logic wr_acc;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic overrun;
    logic unused_dat;

    assign accept = CYC_I & STB_I & ~ACK_O;
    assign rd_acc = accept & ~WE_I;
    assign wr_acc = accept & WE_I;
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_CNT);
    assign pop    = rd_acc & ADR_I & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still takes the byte.
    assign push   = BYTE_STB_I & (~full | pop);
    assign drop   = BYTE_STB_I & full & ~pop;

`ifdef KIA_OVERRUN_FLAG_EN
    assign unused_dat = ^{DAT_I[7:3], DAT_I[1:0]};

    always_ff @(posedge CLK_I or posedge RES_I) begin
        if (RES_I) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (wr_acc && !ADR_I && DAT_I[2]) begin
            overrun <= 1'b0;
        end
    end
`else
    assign unused_dat = ^{DAT_I, drop, wr_acc};
    assign overrun    = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (push && !RES_I) begin
            mem[wr_ptr] <= BYTE_I;
        end
    end

    always_ff @(posedge CLK_I or posedge RES_I) begin
        if (RES_I) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RES_I) begin
        if (RES_I) begin
            ACK_O <= 1'b0;
            DAT_O <= 8'h00;
        end else begin
            ACK_O <= accept;
            if (rd_acc) begin
                if (!ADR_I) begin
                    DAT_O <= {5'b0, overrun, full, empty};
                end else if (empty) begin
                    DAT_O <= 8'h00;
                end else begin
                    DAT_O <= mem[rd_ptr];
                end
            end
        end
    end
endmodule

// File: tb/tb_kia_queue.sv
// tb/tb_kia_queue.sv - directed self-checking bench for kia_queue.
module tb_kia_queue;
    logic       CLK_I = 1'b0;
    logic       RES_I = 1'b1;
    logic       ADR_I = 1'b0;
    logic       WE_I = 1'b0;
    logic       CYC_I = 1'b0;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic       ACK_O;
    logic [7:0] DAT_O;
    logic [7:0] BYTE_I = 8'h00;
    logic       BYTE_STB_I = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

`ifdef KIA_OVERRUN_FLAG_EN
    localparam logic [7:0] OV = 8'h04;
`else
    localparam logic [7:0] OV = 8'h00;
`endif

    kia_queue #(.DEPTH_LOG2(4)) dut (
        .CLK_I(CLK_I), .RES_I(RES_I), .ADR_I(ADR_I), .WE_I(WE_I),
        .CYC_I(CYC_I), .STB_I(STB_I), .DAT_I(DAT_I), .ACK_O(ACK_O),
        .DAT_O(DAT_O), .BYTE_I(BYTE_I), .BYTE_STB_I(BYTE_STB_I)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    task automatic bus(input logic adr, input logic we, input logic [7:0] wd,
                       input logic bs, input logic [7:0] bb, output logic [7:0] rd);
        ADR_I = adr; WE_I = we; DAT_I = wd; CYC_I = 1'b1; STB_I = 1'b1;
        BYTE_STB_I = bs; BYTE_I = bb;
        chk("ack_before", {7'b0, ACK_O}, 8'h00);
        @(posedge CLK_I); #1;
        CYC_I = 1'b0; STB_I = 1'b0; BYTE_STB_I = 1'b0; WE_I = 1'b0;
        chk("ack_pulse", {7'b0, ACK_O}, 8'h01);
        rd = DAT_O;
        @(posedge CLK_I); #1;
        chk("ack_single", {7'b0, ACK_O}, 8'h00);
    endtask

    task automatic rd_chk(input string tag, input logic adr, input logic [7:0] exp_v);
        logic [7:0] d;
        bus(adr, 1'b0, 8'h00, 1'b0, 8'h00, d);
        chk(tag, d, exp_v);
    endtask

    task automatic wr(input logic [7:0] wd);
        logic [7:0] d;
        bus(1'b0, 1'b1, wd, 1'b0, 8'h00, d);
    endtask

    task automatic push(input logic [7:0] b);
        BYTE_I = b; BYTE_STB_I = 1'b1;
        @(posedge CLK_I); #1;
        BYTE_STB_I = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        // Reset state
        #1;
        chk("rst_ack", {7'b0, ACK_O}, 8'h00);
        chk("rst_dat", DAT_O, 8'h00);
        @(posedge CLK_I); #1;
        RES_I = 1'b0;
        @(posedge CLK_I); #1;
        rd_chk("status_after_reset", 1'b0, 8'h01);

        // Two bytes in, two out, then empty head read
        push(8'h1C); push(8'h32);
        rd_chk("status_two", 1'b0, 8'h00);
        rd_chk("head_1c", 1'b1, 8'h1C);
        rd_chk("head_32", 1'b1, 8'h32);
        rd_chk("status_empty", 1'b0, 8'h01);
        rd_chk("head_empty", 1'b1, 8'h00);

        // Overfill: 17 pushes, 0x10 lost
        for (int i = 0; i < 17; i++) push(8'(i));
        rd_chk("status_full_ov", 1'b0, 8'h02 | OV);
        for (int i = 0; i < 16; i++) rd_chk("drain", 1'b1, 8'(i));
        rd_chk("status_drained", 1'b0, 8'h01 | OV);
        rd_chk("head_after_drain", 1'b1, 8'h00);

        // Overrun clear: DAT_I bit2 clear leaves it, bit2 set clears it
        wr(8'h00);
        rd_chk("ov_kept", 1'b0, 8'h01 | OV);
        wr(8'h04);
        rd_chk("ov_cleared", 1'b0, 8'h01);

        // Push coinciding with a head read of an empty queue
        bus(1'b1, 1'b0, 8'h00, 1'b1, 8'h55, d);
        chk("empty_pop_push", d, 8'h00);
        rd_chk("status_one", 1'b0, 8'h00);
        rd_chk("head_55", 1'b1, 8'h55);

        // Full queue, push coincides with pop
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        rd_chk("status_full", 1'b0, 8'h02);
        bus(1'b1, 1'b0, 8'h00, 1'b1, 8'h99, d);
        chk("full_pop_push", d, 8'h20);
        rd_chk("status_still_full", 1'b0, 8'h02);
        for (int i = 1; i < 16; i++) rd_chk("drain2", 1'b1, 8'(8'h20 + i));
        rd_chk("head_99", 1'b1, 8'h99);
        rd_chk("status_empty2", 1'b0, 8'h01);

        // CYC/STB held four cycles on the head register
        push(8'hA1); push(8'hA2); push(8'hA3);
        ADR_I = 1'b1; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
        @(posedge CLK_I); #1;
        chk("hold_ack1", {7'b0, ACK_O}, 8'h01);
        chk("hold_dat1", DAT_O, 8'hA1);
        @(posedge CLK_I); #1;
        chk("hold_ack2", {7'b0, ACK_O}, 8'h00);
        @(posedge CLK_I); #1;
        chk("hold_ack3", {7'b0, ACK_O}, 8'h01);
        chk("hold_dat3", DAT_O, 8'hA2);
        @(posedge CLK_I); #1;
        chk("hold_ack4", {7'b0, ACK_O}, 8'h00);
        CYC_I = 1'b0; STB_I = 1'b0;
        @(posedge CLK_I); #1;
        rd_chk("head_a3", 1'b1, 8'hA3);
        rd_chk("status_empty3", 1'b0, 8'h01);

        // Reset asserted mid-transaction and mid-push
        push(8'h11); push(8'h22);
        rd_chk("pre_reset_head", 1'b1, 8'h11);
        ADR_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; BYTE_STB_I = 1'b1; BYTE_I = 8'h77;
        #2;
        RES_I = 1'b1;
        #1;
        chk("async_ack", {7'b0, ACK_O}, 8'h00);
        chk("async_dat", DAT_O, 8'h00);
        @(posedge CLK_I); #1;
        chk("held_ack", {7'b0, ACK_O}, 8'h00);
        CYC_I = 1'b0; STB_I = 1'b0; BYTE_STB_I = 1'b0;
        RES_I = 1'b0;
        @(posedge CLK_I); #1;
        chk("post_reset_ack", {7'b0, ACK_O}, 8'h00);
        rd_chk("status_post_reset", 1'b0, 8'h01);
        rd_chk("head_post_reset", 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
